// File: rtl/alu_mc.sv
// Multi-cycle RV32I/RV32M execute unit: base ALU ops and branch compares in one
// cycle, multiply/divide iterated one bit per cycle, valid/ready on both sides.
module alu_mc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [4:0]            ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cond
);
    localparam int W       = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] count;

    logic [2:0]   f3_q;
    logic         div_q;
    logic         na_q;
    logic         nb_q;
    logic         bz_q;
    logic [W-1:0] op1_q;
    logic [W-1:0] b_mag;
    logic [2*W:0] acc;
    logic [2*W:0] acc_next;

    logic m_div;
    logic m_sa;
    logic m_sb;
    logic m_na;
    logic m_nb;

    function automatic logic [W-1:0] base_result(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic [3:0]   c);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [SHAMT_W-1:0]  sh;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        base_result = '0;
        case (c[2:0])
            3'b000: base_result = c[3] ? a - b : a + b;
            3'b001: base_result = a << sh;
            3'b010: base_result = {{(W-1){1'b0}}, sa < sb};
            3'b011: base_result = {{(W-1){1'b0}}, a < b};
            3'b100: base_result = a ^ b;
            3'b101: begin
                // Kept as separate statements so the arithmetic shift stays signed.
                if (c[3]) base_result = sa >>> sh;
                else      base_result = a >> sh;
            end
            3'b110: base_result = a | b;
            3'b111: base_result = a & b;
            default: base_result = '0;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [2:0]   f3);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  branch_cond = (a == b);
            3'b001:  branch_cond = (a != b);
            3'b100:  branch_cond = (sa < sb);
            3'b101:  branch_cond = (sa >= sb);
            3'b110:  branch_cond = (a < b);
            3'b111:  branch_cond = (a >= b);
            default: branch_cond = 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic neg);
        logic [W-1:0] n;
        n = ~v + 1'b1;
        magnitude = neg ? n : v;
    endfunction

    // acc = {carry, high, low}; low holds the multiplier and shifts out LSB first.
    function automatic logic [2*W:0] mul_step(input logic [2*W:0] p, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, b} : {(W+1){1'b0}});
        mul_step = {1'b0, sum, p[W-1:1]};
    endfunction

    // acc = {0, remainder, dividend/quotient}; quotient bits enter at the bottom.
    function automatic logic [2*W:0] div_step(input logic [2*W:0] p, input logic [W-1:0] b);
        logic [W:0] rw;
        logic [W:0] diff;
        rw   = p[2*W-1:W-1];
        diff = rw - {1'b0, b};
        if (!diff[W]) div_step = {1'b0, diff[W-1:0], p[W-2:0], 1'b1};
        else          div_step = {1'b0, rw[W-1:0], p[W-2:0], 1'b0};
    endfunction

    function automatic logic [W-1:0] finalize(input logic [2*W:0] p,
                                              input logic [2:0]   f3,
                                              input logic         is_div,
                                              input logic         na,
                                              input logic         nb,
                                              input logic         bz,
                                              input logic [W-1:0] a_raw);
        logic [2*W-1:0] prod;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        prod = p[2*W-1:0];
        q    = p[W-1:0];
        r    = p[2*W-1:W];
        if (!is_div) begin
            if (na ^ nb) prod = ~prod + 1'b1;
            finalize = (f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end else if (bz) begin
            finalize = f3[1] ? a_raw : {W{1'b1}};
        end else if (f3[1]) begin
            finalize = magnitude(r, na);
        end else begin
            finalize = magnitude(q, na ^ nb);
        end
    endfunction

    always_comb begin
        m_div = ctrl[2];
        m_sa  = m_div ? ~ctrl[0] : (ctrl[1:0] != 2'b11);
        m_sb  = m_div ? ~ctrl[0] : ~ctrl[1];
        m_na  = m_sa & op1[W-1];
        m_nb  = m_sb & op2[W-1];
    end

    always_comb begin
        acc_next = div_q ? div_step(acc, b_mag) : mul_step(acc, b_mag);
    end

    // Operand capture at accept, then one iteration per BUSY cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            f3_q  <= ctrl[2:0];
            div_q <= m_div;
            na_q  <= m_na;
            nb_q  <= m_nb;
            bz_q  <= (op2 == '0);
            op1_q <= op1;
            b_mag <= magnitude(op2, m_nb);
            acc   <= {{(W+1){1'b0}}, magnitude(op1, m_na)};
        end else if (state == BUSY) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cond      <= 1'b0;
            count     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (!ctrl[4]) begin
                            result    <= base_result(op1, op2, ctrl[3:0]);
                            cond      <= branch_cond(op1, op2, ctrl[2:0]);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count <= SHAMT_W'(W - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // The last iteration and the sign/special-case fix-up share a cycle.
                    if (count == '0) begin
                        result    <= finalize(acc_next, f3_q, div_q, na_q, nb_q, bz_q, op1_q);
                        cond      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and a 16-bit instance checked against a behavioural
// arithmetic model, plus directed latency, backpressure, flush and reset scenarios.
module tb_alu_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, iv, fl, ordy, sel;
    logic [31:0] a, b;
    logic [4:0]  c;

    logic        iv_a, iv_b, fl_a, fl_b, or_a, or_b;
    logic        ir_a, ov_a, cond_a, ir_b, ov_b, cond_b;
    logic [31:0] res_a;
    logic [15:0] res_b, a16, b16;
    logic        cur_ir, cur_ov, cur_cond;
    logic [31:0] cur_res;

    int n_pass = 0;
    int n_total = 0;

    assign iv_a = iv & ~sel;
    assign iv_b = iv & sel;
    assign fl_a = fl & ~sel;
    assign fl_b = fl & sel;
    assign or_a = ordy & ~sel;
    assign or_b = ordy & sel;
    assign a16  = a[15:0];
    assign b16  = b[15:0];
    assign cur_ir   = sel ? ir_b : ir_a;
    assign cur_ov   = sel ? ov_b : ov_a;
    assign cur_cond = sel ? cond_b : cond_a;
    assign cur_res  = sel ? {16'h0, res_b} : res_a;

    alu_mc #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a),
        .op1(a), .op2(b), .ctrl(c), .out_valid(ov_a), .out_ready(or_a),
        .result(res_a), .cond(cond_a)
    );

    alu_mc #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b),
        .op1(a16), .op2(b16), .ctrl(c), .out_valid(ov_b), .out_ready(or_b),
        .result(res_b), .cond(cond_b)
    );

    // Reference: RISC-V semantics on integers of width w, using 64-bit arithmetic.
    function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] ctl, output logic [31:0] r, output logic cd);
        longint mask, ux, uy, sx, sy, mn, t;
        int sh;
        mask = (longint'(1) <<< w) - 1;
        ux = longint'(x) & mask;
        uy = longint'(y) & mask;
        sx = x[w-1] ? ux - (mask + 1) : ux;
        sy = y[w-1] ? uy - (mask + 1) : uy;
        mn = -(longint'(1) <<< (w - 1));
        sh = int'(uy % w);
        t  = 0;
        cd = 1'b0;
        if (!ctl[4]) begin
            case (ctl[2:0])
                3'd0: t = ctl[3] ? ux - uy : ux + uy;
                3'd1: t = ux <<< sh;
                3'd2: t = longint'(sx < sy);
                3'd3: t = longint'(ux < uy);
                3'd4: t = ux ^ uy;
                3'd5: t = ctl[3] ? (sx >>> sh) : (ux >>> sh);
                3'd6: t = ux | uy;
                default: t = ux & uy;
            endcase
            case (ctl[2:0])
                3'd0: cd = (ux == uy);
                3'd1: cd = (ux != uy);
                3'd4: cd = (sx < sy);
                3'd5: cd = (sx >= sy);
                3'd6: cd = (ux < uy);
                3'd7: cd = (ux >= uy);
                default: cd = 1'b0;
            endcase
        end else begin
            case (ctl[2:0])
                3'd0: t = sx * sy;
                3'd1: t = (sx * sy) >>> w;
                3'd2: t = (sx * uy) >>> w;
                3'd3: t = longint'((longint'(unsigned'(ux)) * longint'(unsigned'(uy))) >> w);
                3'd4: t = (uy == 0) ? mask : ((sx == mn && sy == -1) ? mn : sx / sy);
                3'd5: t = (uy == 0) ? mask : ux / uy;
                3'd6: t = (uy == 0) ? ux : ((sx == mn && sy == -1) ? 0 : sx % sy);
                default: t = (uy == 0) ? ux : ux % uy;
            endcase
        end
        r = 32'(t & mask);
    endfunction

    // Presents one op on the selected instance, measures cycles from accept to
    // out_valid, captures the result and then consumes it.
    task automatic run_op(input bit s, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] ctl, output logic [31:0] r, output logic cd,
                          output int lat);
        int k;
        sel = s; a = x; b = y; c = ctl; iv = 1'b1; k = 0;
        while (!cur_ir && k < 100) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 1;
        while (!cur_ov && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (!cur_ov) lat = -1;
        r = cur_res;
        cd = cur_cond;
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if (ir_a !== 1'b1 || ov_a !== 1'b0) $display("FAIL reset32_hs: ir=%b ov=%b required ir=1 ov=0", ir_a, ov_a);
        else n_pass++;
        n_total++;
        if (res_a !== 32'h0 || cond_a !== 1'b0) $display("FAIL reset32_data: res=%h cond=%b required 0", res_a, cond_a);
        else n_pass++;
        n_total++;
        if (ir_b !== 1'b1 || ov_b !== 1'b0) $display("FAIL reset16_hs: ir=%b ov=%b required ir=1 ov=0", ir_b, ov_b);
        else n_pass++;
        n_total++;
        if (res_b !== 16'h0 || cond_b !== 1'b0) $display("FAIL reset16_data: res=%h cond=%b required 0", res_b, cond_b);
        else n_pass++;
    endtask

    task automatic test_base();
        logic [31:0] x[4], y[4], e[4], r;
        logic [4:0]  cc[4];
        logic        cd;
        int          lat;
        x  = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'h1};
        y  = '{32'h1, 32'h1, 32'd31, 32'hFFFFFFFF};
        cc = '{5'b00000, 5'b01000, 5'b01101, 5'b00011};
        e  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, x[i], y[i], cc[i], r, cd, lat);
            n_total++;
            if (r !== e[i]) $display("FAIL base[%0d]: result %h required %h", i, r, e[i]);
            else n_pass++;
            n_total++;
            if (lat !== 1) $display("FAIL base_lat[%0d]: latency %0d required 1", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        logic [31:0] x[3], y[3], r;
        logic [4:0]  cc[3];
        logic        e[3];
        logic        cd;
        int          lat;
        x  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        y  = '{32'h1, 32'h1, 32'd5};
        cc = '{5'b00100, 5'b00110, 5'b00000};
        e  = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, x[i], y[i], cc[i], r, cd, lat);
            n_total++;
            if (cd !== e[i]) $display("FAIL branch[%0d]: cond %b required %b", i, cd, e[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mul();
        logic [31:0] x[4], y[4], e[4], r;
        logic [4:0]  cc[4];
        logic        cd;
        int          lat;
        x  = '{32'h80000000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
        y  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'd2};
        cc = '{5'b10001, 5'b10011, 5'b10000, 5'b10010};
        e  = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFF4, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, x[i], y[i], cc[i], r, cd, lat);
            n_total++;
            if (r !== e[i] || cd !== 1'b0) $display("FAIL mul[%0d]: result %h cond %b required %h cond 0", i, r, cd, e[i]);
            else n_pass++;
            n_total++;
            if (lat !== 33) $display("FAIL mul_lat[%0d]: latency %0d required 33", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_div();
        logic [31:0] x[6], y[6], e[6], r;
        logic [4:0]  cc[6];
        logic        cd;
        int          lat;
        x  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        y  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        cc = '{5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110};
        e  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, x[i], y[i], cc[i], r, cd, lat);
            n_total++;
            if (r !== e[i]) $display("FAIL div[%0d]: result %h required %h", i, r, e[i]);
            else n_pass++;
            n_total++;
            if (lat !== 33) $display("FAIL div_lat[%0d]: latency %0d required 33", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_w16();
        logic [31:0] x[8], y[8], e[8], r;
        logic [4:0]  cc[8];
        int          el[8];
        logic        cd;
        int          lat;
        x  = '{32'h8000, 32'h1, 32'hFFF9, 32'hFFF9, 32'd5, 32'd5, 32'h8000, 32'h8000};
        y  = '{32'd15, 32'h1F, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF, 32'hFFFF};
        cc = '{5'b01101, 5'b00001, 5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110};
        e  = '{32'hFFFF, 32'h8000, 32'hFFFD, 32'hFFFF, 32'hFFFF, 32'd5, 32'h8000, 32'h0};
        el = '{1, 1, 17, 17, 17, 17, 17, 17};
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, x[i], y[i], cc[i], r, cd, lat);
            n_total++;
            if (r !== e[i]) $display("FAIL w16[%0d]: result %h required %h", i, r, e[i]);
            else n_pass++;
            n_total++;
            if (lat !== el[i]) $display("FAIL w16_lat[%0d]: latency %0d required %0d", i, lat, el[i]);
            else n_pass++;
        end
    endtask

    function automatic logic [31:0] pick(input bit s);
        case ($urandom_range(0, 5))
            0: pick = 32'h0;
            1: pick = 32'hFFFFFFFF;
            2: pick = s ? 32'h8000 : 32'h80000000;
            3: pick = 32'h1;
            default: pick = $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] x, y, r, er;
        logic [4:0]  ctl;
        logic        cd, ec, s;
        int          lat, w;
        for (int i = 0; i < 60; i++) begin
            s   = 1'($urandom_range(0, 1));
            w   = s ? 16 : 32;
            ctl = 5'($urandom);
            x   = pick(s);
            y   = pick(s);
            model(w, x, y, ctl, er, ec);
            run_op(s, x, y, ctl, r, cd, lat);
            n_total++;
            if (r !== er || cd !== ec)
                $display("FAIL rand[%0d] w=%0d ctrl=%b op1=%h op2=%h: result %h cond %b required %h cond %b",
                         i, w, ctl, x, y, r, cd, er, ec);
            else n_pass++;
            n_total++;
            if (lat !== (ctl[4] ? w + 1 : 1))
                $display("FAIL rand_lat[%0d]: latency %0d required %0d", i, lat, ctl[4] ? w + 1 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] er, er2;
        logic        ec, ec2;
        int          bad;
        sel = 1'b0; a = 32'd10; b = 32'd3; c = 5'b01000; iv = 1'b1;
        model(32, a, b, c, er, ec);
        @(posedge clk); #1;
        iv = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ov_a !== 1'b1 || res_a !== er || cond_a !== ec || ir_a !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL hold: %0d unstable cycles required 0 (last res %h required %h)", bad, res_a, er);
        else n_pass++;
        a = 32'h0000F0F0; b = 32'h00000FF0; c = 5'b00111; iv = 1'b1; ordy = 1'b1;
        model(32, a, b, c, er2, ec2);
        @(posedge clk); #1;
        ordy = 1'b0;
        n_total++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL release: ov=%b ir=%b required ov=0 ir=1", ov_a, ir_a);
        else n_pass++;
        @(posedge clk); #1;
        iv = 1'b0;
        n_total++;
        if (ov_a !== 1'b1 || res_a !== er2 || cond_a !== ec2)
            $display("FAIL after_release: ov=%b res=%h cond=%b required ov=1 res=%h cond=%b", ov_a, res_a, cond_a, er2, ec2);
        else n_pass++;
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2;
        logic        c1, c2;
        sel = 1'b0; ordy = 1'b1; iv = 1'b1; a = 32'd5; b = 32'd9; c = 5'b00000;
        model(32, a, b, c, e1, c1);
        @(posedge clk); #1;
        n_total++;
        if (ov_a !== 1'b1 || res_a !== e1) $display("FAIL b2b_first: ov=%b res=%h required ov=1 res=%h", ov_a, res_a, e1);
        else n_pass++;
        a = 32'd20; b = 32'd1; c = 5'b01000;
        model(32, a, b, c, e2, c2);
        @(posedge clk); #1;
        n_total++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL b2b_idle: ov=%b ir=%b required ov=0 ir=1", ov_a, ir_a);
        else n_pass++;
        @(posedge clk); #1;
        iv = 1'b0;
        n_total++;
        if (ov_a !== 1'b1 || res_a !== e2) $display("FAIL b2b_second: ov=%b res=%h required ov=1 res=%h", ov_a, res_a, e2);
        else n_pass++;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] r, er;
        logic        cd, ec;
        int          lat, seen;
        sel = 1'b0; a = 32'd100; b = 32'd7; c = 5'b10100; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        fl = 1'b1;
        @(posedge clk); #1;
        fl = 1'b0;
        n_total++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL flush_busy: ov=%b ir=%b required ov=0 ir=1", ov_a, ir_a);
        else n_pass++;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov_a) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL flush_discard: out_valid seen %0d cycles required 0", seen);
        else n_pass++;
        fl = 1'b1; iv = 1'b1; c = 5'b00000;
        @(posedge clk); #1;
        fl = 1'b0; iv = 1'b0;
        n_total++;
        if (ir_a !== 1'b1 || ov_a !== 1'b0) $display("FAIL flush_drop: ir=%b ov=%b required ir=1 ov=0", ir_a, ov_a);
        else n_pass++;
        model(32, 32'd100, 32'd7, 5'b10100, er, ec);
        run_op(1'b0, 32'd100, 32'd7, 5'b10100, r, cd, lat);
        n_total++;
        if (r !== er || lat !== 33) $display("FAIL flush_after: result %h latency %0d required %h latency 33", r, lat, er);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        logic        cd;
        int          lat;
        sel = 1'b0; a = 32'd3; b = 32'hFFFFFFFC; c = 5'b10000; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL rst_busy: ov=%b ir=%b required ov=0 ir=1", ov_a, ir_a);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        a = 32'd1; b = 32'd2; c = 5'b00000; iv = 1'b1;
        @(posedge clk); #3;
        iv = 1'b0;
        rst = 1'b1;
        #1;
        n_total++;
        if (ov_a !== 1'b0 || res_a !== 32'h0) $display("FAIL rst_done: ov=%b res=%h required ov=0 res=0", ov_a, res_a);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(1'b0, 32'd3, 32'hFFFFFFFC, 5'b10000, r, cd, lat);
        n_total++;
        if (r !== 32'hFFFFFFF4 || lat !== 33) $display("FAIL rst_after: result %h latency %0d required fffffff4 latency 33", r, lat);
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iv = 1'b0; fl = 1'b0; ordy = 1'b0; sel = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_base();
        test_branch();
        test_mul();
        test_div();
        test_w16();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle successor to the single-cycle integer ALU: executes all RV32I register/immediate ALU operations and branch comparisons in one cycle, and the RV32M multiply/divide group with a fixed iterative latency. It sits in the execute stage and uses a valid/ready handshake on both sides, so the pipeline can stall on a busy unit. Width is parametrised, and the shift-amount width follows from it.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 8
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from op2 (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight or held operation
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept (high only in IDLE)
- op1, op2  in  DATA_WIDTH  operands
- ctrl  in  5  {funct7[0] (M-ext), funct7[5], funct3[2:0]}
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- result  out  DATA_WIDTH  ALU/M result
- cond  out  1  branch comparison result, valid with out_valid

## Operation
- Base ops (ctrl[4]=0), decoded on ctrl[3:0]:
  - 0000 ADD; 1000 SUB; ?111 AND; ?110 OR; ?100 XOR
  - ?001 SLL; 0101 SRL; 1101 SRA; ?010 SLT signed; ?011 SLTU
  - Shifts use op2[SHAMT_W-1:0]. SLT/SLTU give 1 or 0 zero-extended.
  - Any other code gives result 0.
- cond, decoded on funct3, for base ops only:
  - 000 eq; 001 ne; 100 lt signed; 101 ge signed; 110 ltu; 111 geu; other funct3 give 0.
  - cond is 0 for M ops.
- M ops (ctrl[4]=1), decoded on funct3:
  - 000 MUL (low W bits); 001 MULH s×s; 010 MULHSU s×u; 011 MULHU u×u (high W bits)
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU
  - ctrl[3] is ignored.
- Multiply: magnitudes are shift-add accumulated, 1 bit per cycle, into a 2W product. The product is negated at completion when the operand signs differ (signed operands only).
- Divide: restoring divide on magnitudes, 1 quotient bit per cycle.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
  - Divide by zero: quotient all-ones; remainder = op1.
  - Signed overflow (op1 = MIN, op2 = −1): quotient = MIN; remainder = 0.
  - Special cases still take the full latency.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch operands and ctrl. Base op → DONE with result registered. M op → BUSY with counter = DATA_WIDTH−1.
  - BUSY: one iteration per cycle. At counter 0, finalise sign/special case → DONE. Otherwise decrement.
  - DONE: out_valid=1; result and cond held stable. On out_ready → IDLE.
- flush in any state → IDLE next edge. Any in-flight result is discarded. A handshake coinciding with flush is dropped.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, result=0, cond=0, counter=0
  - Reset mid-BUSY abandons the operation immediately (asynchronous).
- Base op accepted at edge N → out_valid high from edge N+1.
- M op accepted at edge N → out_valid high from edge N+DATA_WIDTH+1 (33 cycles at W=32).
- Back-to-back: out_ready high in the first DONE cycle → IDLE next cycle, so the next accept is at the earliest 2 cycles after the previous accept (base ops).
- out_ready low: result held indefinitely, in_ready stays 0.
- in_valid while not IDLE is ignored; the upstream must hold it.
- All outputs are registered; no combinational path from in_* to out_*.

## Test plan
- Base ops: ADD 0x7FFFFFFF+1 → 0x80000000; SUB 0−1 → 0xFFFFFFFF; SRA 0x80000000>>>31 → 0xFFFFFFFF; SLTU 1<0xFFFFFFFF → 1.
  - Each out_valid exactly 1 cycle after accept.
- Branch cond: BLT op1=0xFFFFFFFF, op2=1 → cond=1; BLTU same operands → cond=0; BEQ 5,5 → cond=1.
- Multiply:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MUL 3×−4 → 0xFFFFFFF4
  - MULHSU −1×2 → 0xFFFFFFFF
  - out_valid at accept+33.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0
- Backpressure: hold out_ready=0 for 10 cycles after DONE → result/cond stable, in_ready=0. Release → next op accepted 1 cycle later.
- Abort:
  - flush at BUSY counter 10 → IDLE next cycle, no out_valid.
  - rst asserted mid-BUSY → out_valid=0 and in_ready=1 immediately.
  - A new op afterwards completes correctly.
- Repeat the divide and shift cases at DATA_WIDTH=16 with scaled values (e.g. SRA 0x8000>>>15 → 0xFFFF, latency 17).
